// File: rtl/mdu_pkg.sv
// Shared op codes, latencies and decode helpers for the multiply/divide unit.
// The decode helpers are also used by the stall unit so both sides agree on codes.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W        = 4;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_e;

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Any op that touches HI/LO; codes 9-15 fall outside and behave as NONE.
    function automatic logic is_mdu(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

    // D-stage hold: covers the start cycle itself, before busy rises.
    function automatic logic mdu_stall(input logic [3:0] d_op, input logic busy,
                                       input logic e_start, input logic [3:0] e_op);
        return is_mdu(d_op) && (busy || (e_start && is_muldiv(e_op)));
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational 64-bit product and quotient/remainder with signed/unsigned handling.
module mdu_core
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        dz_o
);

    logic [63:0] prod_s, prod_u;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b, uq, ur;

    // Signed divide runs on magnitudes; signs are reapplied afterwards so that the
    // quotient truncates toward zero and the remainder follows the dividend.
    always_comb begin
        prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        prod_u = {32'b0, a_i} * {32'b0, b_i};
        neg_a  = (op_i == OP_DIV) && a_i[31];
        neg_b  = (op_i == OP_DIV) && b_i[31];
        mag_a  = neg_a ? -a_i : a_i;
        mag_b  = neg_b ? -b_i : b_i;
        dz_o   = (b_i == 32'd0);
        div_b  = dz_o ? 32'd1 : mag_b;
        uq     = mag_a / div_b;
        ur     = mag_a % div_b;
        hi_o   = 32'd0;
        lo_o   = 32'd0;
        case (op_i)
            OP_MULT:          {hi_o, lo_o} = prod_s;
            OP_MULTU:         {hi_o, lo_o} = prod_u;
            OP_DIV, OP_DIVU: begin
                lo_o = (neg_a ^ neg_b) ? -uq : uq;
                hi_o = neg_a ? -ur : ur;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV into private HI/LO, plus MF*/MT*.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_out
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      core_hi, core_lo;
    logic             core_dz;

    mdu_core u_core (
        .op_i (mdu_op),
        .a_i  (rs_val),
        .b_i  (rt_val),
        .hi_o (core_hi),
        .lo_o (core_lo),
        .dz_o (core_dz)
    );

    // State, counter, pending result and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Issue in IDLE (latch result, load latency, or MT* write); count down and commit in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_muldiv(mdu_op)) begin
                        state_d   = RUN;
                        cnt_d     = is_div(mdu_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        pend_hi_d = core_hi;
                        pend_lo_d = core_lo;
                        pend_dz_d = is_div(mdu_op) && core_dz;
                    end else if (mdu_op == OP_MTHI) begin
                        hi_d = rs_val;
                    end else if (mdu_op == OP_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MFHI/MFLO result, independent of busy.
    always_comb begin
        rd_out = 32'd0;
        if (mdu_op == OP_MFHI)      rd_out = hi_q;
        else if (mdu_op == OP_MFLO) rd_out = lo_q;
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized and directed bench for mdu_unit against an arithmetic HI/LO model.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hi, lo, rd_out;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of a mul/div on HI/LO, from plain arithmetic.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_DIV: if (b != 32'd0) begin
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            OP_DIVU: if (b != 32'd0) begin
                m_lo = a / b; m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    task automatic check_mf(input string tag);
        mdu_op = OP_MFHI; #1;
        chk({tag, ".mfhi"}, rd_out, m_hi);
        mdu_op = OP_MFLO; #1;
        chk({tag, ".mflo"}, rd_out, m_lo);
        mdu_op = 4'd12; #1;
        chk({tag, ".rd_none"}, rd_out, 32'd0);
        mdu_op = OP_NONE;
    endtask

    // Issue one mul/div, measure the busy window (bounded), then check HI/LO.
    task automatic run_md(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        model_op(op, a, b);
        start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
        tick();
        start = 1'b0; mdu_op = OP_NONE; rs_val = $urandom; rt_val = $urandom;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk({tag, ".busy_len"}, 32'(n), (op == OP_DIV || op == OP_DIVU) ? 32'd10 : 32'd5);
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
    endtask

    task automatic run_mt(input logic [3:0] op, input logic [31:0] v);
        start = 1'b1; mdu_op = op; rs_val = v;
        tick();
        start = 1'b0; mdu_op = OP_NONE;
        if (op == OP_MTHI) m_hi = v; else m_lo = v;
    endtask

    initial begin
        int          n, k;
        logic [31:0] a, b;
        logic [3:0]  ops [6];
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV;
        ops[3] = OP_DIVU; ops[4] = OP_MTHI;  ops[5] = OP_MTLO;

        reset = 1'b1; start = 1'b0; mdu_op = OP_NONE; rs_val = '0; rt_val = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.rd", rd_out, 32'd0);

        run_md("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5);
        chk("mult_neg.hi_c", hi, 32'hFFFFFFFF);
        chk("mult_neg.lo_c", lo, 32'hFFFFFFF1);
        check_mf("mult_neg");
        run_md("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2);
        chk("multu.hi_c", hi, 32'h00000001);
        chk("multu.lo_c", lo, 32'hFFFFFFFE);
        run_md("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div_neg.lo_c", lo, 32'hFFFFFFFD);
        chk("div_neg.hi_c", hi, 32'hFFFFFFFF);
        run_md("divu", OP_DIVU, 32'd7, 32'd2);
        chk("divu.lo_c", lo, 32'd3);
        chk("divu.hi_c", hi, 32'd1);
        run_md("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf.lo_c", lo, 32'h80000000);
        chk("div_ovf.hi_c", hi, 32'd0);

        run_mt(OP_MTHI, 32'h12345678);
        check_mf("mthi");
        run_mt(OP_MTLO, 32'h9ABCDEF0);
        check_mf("mtlo");
        run_md("divu_z", OP_DIVU, 32'd99, 32'd0);
        chk("divu_z.hi_c", hi, 32'h12345678);
        chk("divu_z.lo_c", lo, 32'h9ABCDEF0);
        run_md("div_z", OP_DIV, 32'h80000001, 32'd0);

        // Reset in the 4th busy cycle of a DIV discards everything.
        start = 1'b1; mdu_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        start = 1'b0; mdu_op = OP_NONE;
        tick(); tick(); tick();
        chk("rstmid.busy4", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.hi", hi, 32'd0);
        chk("rstmid.lo", lo, 32'd0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy) n++;
            tick();
        end
        chk("rstmid.no_commit_busy", 32'(n), 32'd0);
        chk("rstmid.hi_after", hi, 32'd0);
        chk("rstmid.lo_after", lo, 32'd0);

        // A MULT issued while busy must be dropped.
        model_op(OP_MULT, 32'd1234, 32'd5678);
        start = 1'b1; mdu_op = OP_MULT; rs_val = 32'd1234; rt_val = 32'd5678;
        tick();
        start = 1'b0; mdu_op = OP_NONE;
        n = 0;
        while (busy && n < 40) begin
            if (n == 2) begin
                start = 1'b1; mdu_op = OP_MULT; rs_val = 32'hDEAD; rt_val = 32'hBEEF;
            end else begin
                start = 1'b0; mdu_op = OP_NONE;
            end
            n++;
            tick();
        end
        start = 1'b0; mdu_op = OP_NONE;
        chk("ign.busy_len", 32'(n), 32'd5);
        chk("ign.hi", hi, m_hi);
        chk("ign.lo", lo, m_lo);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) n++;
            tick();
        end
        chk("ign.no_second", 32'(n), 32'd0);

        // Randomized sequence, back-to-back issue right after each commit.
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'(k + 1);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            if (k >= 4) begin
                run_mt(ops[k], a);
                check_mf($sformatf("rnd%0d.mt", i));
            end else begin
                run_md($sformatf("rnd%0d", i), ops[k], a, b);
                check_mf($sformatf("rnd%0d", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit for the 5-stage MIPS pipeline's E stage. It takes the forwarded rs/rt operands (GRF read data after bypass), runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency into private HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. Its `busy` output feeds the D-stage stall unit. Its `rd_out` result travels down the pipeline to the GRF write port.

## Interface
- MULT_LAT, 5, cycles `busy` stays high after a MULT/MULTU start
- DIV_LAT, 10, cycles `busy` stays high after a DIV/DIVU start
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  issue qualifier: E-stage instruction is an MDU op and is not a bubble
- mdu_op  in  4  operation code, values from mdu_pkg
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  a multiply/divide is in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- rd_out  out  32  combinational result for MFHI/MFLO: hi or lo, else 0

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9–15 are treated as NONE.
- Start of a multiply or divide (`start`=1 with op MULT/MULTU/DIV/DIVU, and `busy`=0):
  - The result is computed at the start edge and latched into pending registers pend_hi/pend_lo.
  - The counter loads the op's latency.
  - `busy` is set.
- MULT: signed 32×32→64. {pend_hi, pend_lo} = the 64-bit product.
- MULTU: the same with unsigned operands.
- DIV: signed. pend_lo = quotient truncated toward zero; pend_hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_val=0): the op still takes DIV_LAT cycles, but HI/LO stay unchanged at commit.
- 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0.
- Commit: when the counter reaches 1 and `busy`=1, the next edge writes hi/lo from pend_* (unless divide by zero) and clears `busy`.
- MTHI/MTLO with `start`=1 and `busy`=0: write rs_val to hi/lo at that edge.
- Anything issued while `busy`=1 (start, MT*) is ignored. The stall unit guarantees this cannot happen.
- rd_out ignores `busy`. The stall unit holds MFHI/MFLO in D until `busy`=0.
- States are IDLE and RUN, encoded by `busy`:
  - IDLE→RUN on a mul/div start.
  - RUN→IDLE on commit.
  - Any state→IDLE on reset.

## Timing
- Reset values: hi=0, lo=0, pend_*=0, counter=0, busy=0, rd_out=0.
- Start sampled at edge E0: `busy`=1 for exactly N cycles (edges E1..EN are inside RUN). At edge EN, hi/lo update and `busy` falls together. The new values are visible in the cycle after EN.
- Stall condition to export (computed in the stall unit, documented here): D-stage MDU instruction AND (`busy` OR E-stage `start` with a mul/div op). This covers the start cycle itself, before `busy` rises.
- MTHI/MTLO take effect at the issuing edge. A following MFHI in the next cycle reads the new value.
- Reset mid-RUN, at any count: the next edge clears everything, the pending result is discarded, and hi/lo return to 0.
- Back-to-back: a new mul/div may start in the first cycle with `busy`=0, i.e. the cycle after the commit edge.
- rd_out is purely combinational from mdu_op, hi and lo.

## Structure
- mdu_pkg holds:
  - the op-code localparams NONE..MTLO
  - MULT_LAT and DIV_LAT defaults
  - the counter width (4 bits, enough for 10)
  - the shared decode/control unit, so that start/mdu_op generation and the stall unit use identical codes
- One optional sub-module, mdu_core: the combinational 64-bit product and quotient/remainder with signed/unsigned handling.
- mdu_unit owns the counter, the pending/HI/LO registers and the write control.

## Test plan
- Reset then MULT rs=0xFFFFFFFD (−3), rt=5:
  - `busy` is high for 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - MFHI gives rd_out=0xFFFFFFFF.
- MULTU rs=0xFFFFFFFF, rt=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=2:
  - `busy` is high for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU rs=7, rt=2 then gives lo=3, hi=1.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0, then DIVU with rt=0:
  - `busy` is high for 10 cycles.
  - hi/lo remain 0x12345678/0x9ABCDEF0.
- DIV started; reset asserted at the 4th busy cycle → next cycle busy=0, hi=lo=0, and no later commit occurs.
- MULT issued while busy=1 → ignored: the first result commits on time and no second busy period follows.
